// File: rtl/digitalclock_timekeeper_if.sv
// Signal bundle between the digital-clock mode FSM / display path and the
// time-of-day counter. The master side is the mode FSM plus display consumer;
// the slave side is the timekeeper itself.
// Optional macro: TIMEKEEPER_12H_EN adds the 12-hour view (hours12, pm).
interface digitalclock_timekeeper_if;
   logic       set_hours;
   logic       set_minutes;
   logic       inc;
   logic [4:0] hours;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic       sec_tick;
`ifdef TIMEKEEPER_12H_EN
   logic [3:0] hours12;
   logic       pm;
`endif

`ifdef TIMEKEEPER_12H_EN
   modport master (
      output set_hours, set_minutes, inc,
      input  hours, minutes, seconds, sec_tick, hours12, pm
   );
   modport slave (
      input  set_hours, set_minutes, inc,
      output hours, minutes, seconds, sec_tick, hours12, pm
   );
`else
   modport master (
      output set_hours, set_minutes, inc,
      input  hours, minutes, seconds, sec_tick
   );
   modport slave (
      input  set_hours, set_minutes, inc,
      output hours, minutes, seconds, sec_tick
   );
`endif
endinterface

// File: rtl/digitalclock_timekeeper.sv
// Time-of-day counter: divides clk down to a 1 Hz tick and keeps HH:MM:SS
// (24-hour) in run mode; in set mode timekeeping freezes and each rising edge
// of the debounced inc button advances hours or minutes.
// Optional macro: TIMEKEEPER_12H_EN adds combinational hours12/pm outputs
// derived from the 24-hour count. CLK_FREQ must be at least 2.
module digitalclock_timekeeper #(
   parameter int unsigned CLK_FREQ = 50000000,
   parameter int unsigned PRESC_W  = $clog2(CLK_FREQ)
) (
   input logic                      clk,
   input logic                      rst,
   digitalclock_timekeeper_if.slave tk
);

   localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(CLK_FREQ - 1);

   typedef enum logic [1:0] {
      MODE_RUN,
      MODE_SET_HOURS,
      MODE_SET_MINUTES
   } mode_e;

   mode_e              mode;
   logic               inc_rise;
   logic               presc_tc;

   logic [PRESC_W-1:0] presc_q,   presc_d;
   logic [4:0]         hours_q,   hours_d;
   logic [5:0]         minutes_q, minutes_d;
   logic [5:0]         seconds_q, seconds_d;
   logic               tick_q,    tick_d;
   logic               inc_q;

   // Mode decode; set_hours wins when the FSM drives both set lines.
   always_comb begin
      mode = MODE_RUN;
      if (tk.set_hours) begin
         mode = MODE_SET_HOURS;
      end else if (tk.set_minutes) begin
         mode = MODE_SET_MINUTES;
      end
   end

   assign inc_rise = tk.inc & ~inc_q;
   assign presc_tc = (presc_q == PRESC_TC);

   // Button edge-detect history, so a held button counts once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inc_q <= 1'b0;
      end else begin
         inc_q <= tk.inc;
      end
   end

   // Next-state: run-mode prescaler and full carry chain, or set-mode edits.
   always_comb begin
      presc_d   = presc_q;
      hours_d   = hours_q;
      minutes_d = minutes_q;
      seconds_d = seconds_q;
      tick_d    = 1'b0;

      unique case (mode)
         MODE_RUN: begin
            if (presc_tc) begin
               presc_d = '0;
               tick_d  = 1'b1;
               if (seconds_q == 6'd59) begin
                  seconds_d = '0;
                  if (minutes_q == 6'd59) begin
                     minutes_d = '0;
                     hours_d   = (hours_q == 5'd23) ? '0 : hours_q + 5'd1;
                  end else begin
                     minutes_d = minutes_q + 6'd1;
                  end
               end else begin
                  seconds_d = seconds_q + 6'd1;
               end
            end else begin
               presc_d = presc_q + PRESC_W'(1);
            end
         end

         MODE_SET_HOURS: begin
            presc_d   = '0;
            seconds_d = '0;
            if (inc_rise) begin
               hours_d = (hours_q == 5'd23) ? '0 : hours_q + 5'd1;
            end
         end

         MODE_SET_MINUTES: begin
            presc_d   = '0;
            seconds_d = '0;
            if (inc_rise) begin
               minutes_d = (minutes_q == 6'd59) ? '0 : minutes_q + 6'd1;
            end
         end

         default: begin
            presc_d = '0;
         end
      endcase
   end

   // Timekeeping state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_q   <= '0;
         hours_q   <= '0;
         minutes_q <= '0;
         seconds_q <= '0;
         tick_q    <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         hours_q   <= hours_d;
         minutes_q <= minutes_d;
         seconds_q <= seconds_d;
         tick_q    <= tick_d;
      end
   end

   assign tk.hours    = hours_q;
   assign tk.minutes  = minutes_q;
   assign tk.seconds  = seconds_q;
   assign tk.sec_tick = tick_q;

`ifdef TIMEKEEPER_12H_EN
   logic [3:0] hours12;
   logic       pm;

   // 12-hour view of the 24-hour count: 0 shows as 12 AM, 12 as 12 PM.
   always_comb begin
      hours12 = 4'd12;
      pm      = (hours_q >= 5'd12);
      if (hours_q == 5'd0) begin
         hours12 = 4'd12;
      end else if (hours_q > 5'd12) begin
         hours12 = 4'(hours_q - 5'd12);
      end else begin
         hours12 = 4'(hours_q);
      end
   end

   assign tk.hours12 = hours12;
   assign tk.pm      = pm;
`endif

endmodule

// File: tb/tb_digitalclock_timekeeper.sv
// Self-checking bench for digitalclock_timekeeper with CLK_FREQ=4. The
// reference keeps time as seconds-since-midnight plus cycles-into-second.
module tb_digitalclock_timekeeper;

   localparam int unsigned CLK_FREQ = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   digitalclock_timekeeper_if tk ();

   digitalclock_timekeeper #(
      .CLK_FREQ (CLK_FREQ)
   ) dut (
      .clk (clk),
      .rst (rst),
      .tk  (tk)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int m_tod  = 0;   // seconds since midnight
   int m_cyc  = 0;   // clock cycles elapsed in the current second
   bit m_tick = 1'b0;
   bit m_incq = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input int exp);
      n_checks++;
      if (obs !== 32'(exp)) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_tod  = 0;
      m_cyc  = 0;
      m_tick = 1'b0;
      m_incq = 1'b0;
   endtask

   // Advance the reference by one clock edge using the inputs now applied.
   task automatic model_edge();
      bit sh, sm, rise;
      int h, mi;
      sh     = tk.set_hours;
      sm     = tk.set_minutes;
      rise   = tk.inc && !m_incq;
      m_incq = tk.inc;
      m_tick = 1'b0;
      if (sh || sm) begin
         m_cyc = 0;
         m_tod = m_tod - (m_tod % 60);
         if (rise) begin
            h  = m_tod / 3600;
            mi = (m_tod / 60) % 60;
            if (sh) h = (h + 1) % 24;
            else    mi = (mi + 1) % 60;
            m_tod = h * 3600 + mi * 60;
         end
      end else if (m_cyc == CLK_FREQ - 1) begin
         m_cyc  = 0;
         m_tod  = (m_tod + 1) % 86400;
         m_tick = 1'b1;
      end else begin
         m_cyc++;
      end
   endtask

   task automatic check_all(input string tag);
      int h;
      h = m_tod / 3600;
      check_eq({tag, ".hours"},    tk.hours,    h);
      check_eq({tag, ".minutes"},  tk.minutes,  (m_tod / 60) % 60);
      check_eq({tag, ".seconds"},  tk.seconds,  m_tod % 60);
      check_eq({tag, ".sec_tick"}, tk.sec_tick, int'(m_tick));
`ifdef TIMEKEEPER_12H_EN
      check_eq({tag, ".hours12"},  tk.hours12,  (h % 12 == 0) ? 12 : h % 12);
      check_eq({tag, ".pm"},       tk.pm,       (h >= 12) ? 1 : 0);
`endif
   endtask

   task automatic step(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic pulse_inc(input string tag);
      tk.inc = 1'b1;
      step(tag);
      tk.inc = 1'b0;
      step(tag);
   endtask

   task automatic set_mode_to(input bit sh, input bit sm);
      tk.set_hours   = sh;
      tk.set_minutes = sm;
   endtask

   task automatic preload(input int h, input int mi);
      set_mode_to(1'b1, 1'b0);
      for (int i = 0; i < 24 && (m_tod / 3600) != h; i++) pulse_inc("preload_h");
      set_mode_to(1'b0, 1'b1);
      for (int i = 0; i < 60 && ((m_tod / 60) % 60) != mi; i++) pulse_inc("preload_m");
      check_eq("preload_hours",   tk.hours,   h);
      check_eq("preload_minutes", tk.minutes, mi);
   endtask

   int ticks;

   initial begin
      tk.set_hours   = 1'b0;
      tk.set_minutes = 1'b0;
      tk.inc         = 1'b0;
      model_reset();

      // reset held: outputs clear and stay clear across edges
      repeat (3) @(posedge clk);
      #1;
      check_all("reset");
      rst = 1'b1;

      // 12 run cycles: ticks on cycles 4, 8, 12
      ticks = 0;
      for (int c = 1; c <= 12; c++) begin
         step("run12");
         if (tk.sec_tick === 1'b1) begin
            ticks++;
            check_eq("tick_cycle", c % CLK_FREQ, 0);
            check_eq("tick_seconds", tk.seconds, c / CLK_FREQ);
         end
      end
      check_eq("run12_ticks", ticks, 3);
      check_eq("run12_seconds", tk.seconds, 3);

      // preload 23:59 then roll through midnight
      preload(23, 59);
      set_mode_to(1'b0, 1'b0);
      for (int i = 0; i < 59 * CLK_FREQ; i++) step("to_2359");
      check_eq("at_235959_h", tk.hours, 23);
      check_eq("at_235959_m", tk.minutes, 59);
      check_eq("at_235959_s", tk.seconds, 59);
      for (int i = 0; i < CLK_FREQ; i++) step("midnight");
      check_eq("midnight_h", tk.hours, 0);
      check_eq("midnight_m", tk.minutes, 0);
      check_eq("midnight_s", tk.seconds, 0);
      check_eq("midnight_tick", tk.sec_tick, 1);

      // held button wraps hours 23->0 exactly once
      preload(23, 0);
      set_mode_to(1'b1, 1'b0);
      tk.inc = 1'b1;
      for (int i = 0; i < 10; i++) step("held_inc");
      tk.inc = 1'b0;
      check_eq("held_hours", tk.hours, 0);
      check_eq("held_minutes", tk.minutes, 0);
      check_eq("held_seconds", tk.seconds, 0);

      // minute wrap without hour carry
      preload(5, 59);
      pulse_inc("min_wrap");
      check_eq("min_wrap_m", tk.minutes, 0);
      check_eq("min_wrap_h", tk.hours, 5);

      // terminal count coinciding with set_minutes rising
      set_mode_to(1'b0, 1'b0);
      for (int i = 0; i < 2 * CLK_FREQ && m_cyc != CLK_FREQ - 1; i++) step("seek_tc");
      check_eq("seek_tc_found", m_cyc, CLK_FREQ - 1);
      set_mode_to(1'b0, 1'b1);
      step("tc_vs_set");
      check_eq("tc_vs_set_tick", tk.sec_tick, 0);
      check_eq("tc_vs_set_sec", tk.seconds, 0);
      check_eq("tc_vs_set_min", tk.minutes, 0);
      // leave set mode with inc rising on the same cycle: ignored
      set_mode_to(1'b0, 1'b0);
      tk.inc = 1'b1;
      for (int i = 1; i < CLK_FREQ; i++) begin
         step("after_set");
         check_eq("after_set_notick", tk.sec_tick, 0);
      end
      tk.inc = 1'b0;
      step("after_set");
      check_eq("after_set_tick", tk.sec_tick, 1);
      check_eq("after_set_min", tk.minutes, 0);

      // randomized segments of run / set modes with random button activity
      for (int seg = 0; seg < 120; seg++) begin
         int sel, len;
         sel = $urandom_range(9, 0);
         len = $urandom_range(40, 1);
         if (sel < 5)      set_mode_to(1'b0, 1'b0);
         else if (sel < 7) set_mode_to(1'b1, 1'b0);
         else if (sel < 9) set_mode_to(1'b0, 1'b1);
         else              set_mode_to(1'b1, 1'b1);
         for (int i = 0; i < len; i++) begin
            tk.inc = ($urandom_range(9, 0) < 4);
            step("random");
         end
      end
      tk.inc = 1'b0;

`ifdef TIMEKEEPER_12H_EN
      preload(13, 0);
      check_eq("h13_hours12", tk.hours12, 1);
      check_eq("h13_pm", tk.pm, 1);
`endif

      // asynchronous reset mid-count at 12:34:56
      preload(12, 34);
      set_mode_to(1'b0, 1'b0);
      for (int i = 0; i < 56 * CLK_FREQ; i++) step("to_123456");
      check_eq("at_123456_h", tk.hours, 12);
      check_eq("at_123456_m", tk.minutes, 34);
      check_eq("at_123456_s", tk.seconds, 56);
      #3;
      rst = 1'b0;
      model_reset();
      #1;
      check_all("async_rst");
      check_eq("async_rst_h", tk.hours, 0);
      @(posedge clk);
      #1;
      check_all("rst_hold");
      rst = 1'b1;
      for (int i = 0; i < CLK_FREQ; i++) step("post_rst");
      check_eq("post_rst_s", tk.seconds, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/digitalclock_timekeeper.md
Name: digitalclock_timekeeper

Overview:
- Time-of-day counter stage directly downstream of the digital-clock mode FSM; consumes its set_hours / set_minutes outputs.
- Run mode: divides the system clock down to a 1 Hz tick and keeps HH:MM:SS in 24-hour format.
- Set mode: freezes timekeeping, and each press of the increment button advances hours or minutes.
- Outputs feed the display/segment-decode stage.

Parameters:
- CLK_FREQ, 50000000, system clock cycles per second; prescaler terminal count is CLK_FREQ-1; must be >= 2.
- PRESC_W, $clog2(CLK_FREQ), prescaler counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous assert, active-low; clears all state.
- set_hours  input  1  from mode FSM; hour-set mode active.
- set_minutes  input  1  from mode FSM; minute-set mode active.
- inc  input  1  increment button level, already synchronised/debounced; block edge-detects it.
- hours  output  5  0..23, registered.
- minutes  output  6  0..59, registered.
- seconds  output  6  0..59, registered.
- sec_tick  output  1  one-cycle pulse at each run-mode second boundary, registered.

Behaviour:
- Reset (rst=0, async): hours=0, minutes=0, seconds=0, sec_tick=0, prescaler=0, inc_q=0. These values are held while rst=0. Counting resumes on the first clk edge after release.
- Edge detect: inc_q <= inc every cycle. inc_rise = inc & ~inc_q. A held button yields exactly one increment.
- Mode decode: set_mode = set_hours | set_minutes. If both are asserted (illegal), set_hours has priority.
- Run mode (set_mode=0):
  - Prescaler counts 0..CLK_FREQ-1 and wraps.
  - On the cycle the prescaler equals CLK_FREQ-1, the next edge sets sec_tick=1 for exactly one cycle and increments seconds.
  - Carry chain is evaluated in one cycle:
    - seconds 59->0 carries into minutes.
    - minutes 59->0 carries into hours.
    - hours 23->0 with no further carry.
  - 23:59:59 + tick -> 00:00:00 on the same edge.
  - inc_rise is ignored in run mode.
- Set mode (set_mode=1):
  - Prescaler is held at 0, sec_tick=0, and seconds is cleared to 0 on the first set-mode edge and held there.
  - inc_rise with set_hours: hours <= (hours==23) ? 0 : hours+1. Minutes are unchanged.
  - inc_rise with set_minutes only: minutes <= (minutes==59) ? 0 : minutes+1. No carry into hours.
  - Update is visible on the edge after the cycle in which inc_rise is high (1-cycle latency).
- Simultaneous events:
  - Prescaler at terminal count in the same cycle set_mode rises: set mode wins, with no tick and no carry.
  - inc rising in the same cycle set_mode falls: ignored, because run-mode rules apply.
- Leaving set mode: prescaler restarts from 0. The first sec_tick occurs CLK_FREQ cycles after the first run-mode cycle.
- Reset mid-operation: asynchronous clear, regardless of prescaler phase or set mode.
- All arithmetic is unsigned. The compare-to-limit wrap is explicit; no reliance on binary overflow.

Optional Feature:
- Macro TIMEKEEPER_12H_EN.
- Defined: adds outputs hours12 (4 bits, 1..12) and pm (1 bit), both combinational from hours:
  - hours 0 -> 12, pm=0.
  - hours 1..11 -> same value, pm=0.
  - hours 12 -> 12, pm=1.
  - hours 13..23 -> hours-12, pm=1.
  - Internal counting stays 24-hour.
- Not defined: ports are absent and behaviour is 24-hour only.

Test Plan:
- CLK_FREQ=4, reset then run 12 cycles -> sec_tick pulses on cycles 4, 8 and 12 after release; seconds = 1, 2, 3.
- Preload via set mode to 23:59, return to run, wait 59 ticks then 1 more -> 23:59:59 then 00:00:00 on the same edge, sec_tick=1.
- set_hours=1, hours=23, inc held high 10 cycles -> hours=0 exactly once; minutes unchanged; seconds=0.
- set_minutes=1, minutes=59, hours=5, one inc pulse -> minutes=0, hours stays 5.
- Prescaler at CLK_FREQ-1 while set_minutes rises the same cycle -> no sec_tick, seconds=0, no minute carry. After set_minutes falls, first tick arrives exactly 4 cycles later.
- rst asserted mid-count at 12:34:56, asynchronous to clk -> all outputs 0 before the next clk edge. With TIMEKEEPER_12H_EN: hours=0 -> hours12=12, pm=0; hours=13 -> hours12=1, pm=1.
